rect_decrypt: RTL and testbench

RECT_DECRYPT -- requirements
Module: rect_decrypt

---
 rtl/rect_pkg.sv | 36 +++
 rtl/rect_inv_sbox.sv | 11 +
 rtl/rect_decrypt.sv | 189 ++++++++++++++++++
 tb/tb_rect_decrypt.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rect_pkg.sv
// Shared constants for the RECTANGLE-80 decryptor: round count, row rotations,
// S-box tables, round constants and the FSM state type.
package rect_pkg;

  localparam int NR = 25;
  localparam int ROT [4] = '{0, 1, 12, 13};
  localparam logic [4:0] RC_LAST = 5'(NR - 1);

  localparam logic [3:0] SBOX [16] = '{
    4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
    4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h9, 4'h4, 4'hF, 4'hA, 4'hE, 4'h1, 4'h0, 4'h6,
    4'hC, 4'h7, 4'h3, 4'h8, 4'h2, 4'hB, 4'h5, 4'hD
  };

  // 5-bit LFSR sequence rc' = {rc[3:0], rc[4]^rc[2]} seeded with 0x01
  localparam logic [4:0] RC [NR] = '{
    5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C,
    5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h11,
    5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E, 5'h1D
  };

  typedef enum logic [1:0] {IDLE, KEXP, DEC, FIN} state_t;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
    rotl16 = (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
    rotr16 = (x >> n) | (x << (16 - n));
  endfunction

endpackage

// File: rtl/rect_inv_sbox.sv
// Combinational 4-bit RECTANGLE inverse S-box.
module rect_inv_sbox
  import rect_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = INV_SBOX[i_nib];

endmodule

// File: rtl/rect_decrypt.sv
// Iterative RECTANGLE-80 decryptor: expands the master key to K25, then runs the rounds backwards.
// Optional RECT_DEC_KEYCACHE_EN caches K25 for a repeated master key and skips expansion.
module rect_decrypt
  import rect_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] ct_in,
  input  logic [79:0] key_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] pt_out
);

  // IDLE wait start | KEXP forward key steps to K25 | DEC inverse rounds | FIN emit plaintext
  state_t      r_state, w_next;
  logic [63:0] r_state_reg, r_pt;
  logic [79:0] r_key;
  logic [4:0]  r_rcnt;
  logic        r_done;
  logic        w_hit;
  logic [79:0] w_key_load;
  logic [4:0]  w_rc;

  assign w_rc = RC[r_rcnt];

  logic [63:0] w_x, w_sh, w_inv;
  logic [3:0]  w_scol [16];

  assign w_x  = r_state_reg ^ r_key[63:0];
  assign w_sh = {rotr16(w_x[63:48], ROT[3]), rotr16(w_x[47:32], ROT[2]),
                 rotr16(w_x[31:16], ROT[1]), rotr16(w_x[15:0], ROT[0])};

  for (genvar j = 0; j < 16; j++) begin : g_state_sb
    rect_inv_sbox u_sb (
      .i_nib({w_sh[48+j], w_sh[32+j], w_sh[16+j], w_sh[j]}),
      .o_nib(w_scol[j])
    );
  end

  always_comb begin
    w_inv = '0;
    for (int j = 0; j < 16; j++) begin
      w_inv[j]    = w_scol[j][0];
      w_inv[16+j] = w_scol[j][1];
      w_inv[32+j] = w_scol[j][2];
      w_inv[48+j] = w_scol[j][3];
    end
  end

  logic [15:0] w_fs [4];
  logic [3:0]  w_fnib;
  logic [79:0] w_key_fwd;

  always_comb begin
    w_fnib = '0;
    for (int i = 0; i < 4; i++) w_fs[i] = r_key[16*i +: 16];
    for (int j = 0; j < 4; j++) begin
      w_fnib      = SBOX[{r_key[48+j], r_key[32+j], r_key[16+j], r_key[j]}];
      w_fs[0][j]  = w_fnib[0];
      w_fs[1][j]  = w_fnib[1];
      w_fs[2][j]  = w_fnib[2];
      w_fs[3][j]  = w_fnib[3];
    end
    w_key_fwd = {w_fs[0],
                 rotl16(w_fs[3], 12) ^ r_key[79:64],
                 w_fs[3],
                 w_fs[2],
                 rotl16(w_fs[0], 8) ^ w_fs[1] ^ {11'd0, w_rc}};
  end

  // Inverse key step undoes the row mixing first, then the S-box on the low four columns
  logic [15:0] w_ir0, w_ir1, w_ir2, w_ir3, w_ir4;
  logic [3:0]  w_kcol [4];
  logic [15:0] w_kr [4];
  logic [79:0] w_key_inv;

  assign w_ir0 = r_key[79:64];
  assign w_ir1 = r_key[15:0] ^ {11'd0, w_rc} ^ rotl16(r_key[79:64], 8);
  assign w_ir2 = r_key[31:16];
  assign w_ir3 = r_key[47:32];
  assign w_ir4 = r_key[63:48] ^ rotl16(r_key[47:32], 12);

  for (genvar j = 0; j < 4; j++) begin : g_key_sb
    rect_inv_sbox u_sb (
      .i_nib({w_ir3[j], w_ir2[j], w_ir1[j], w_ir0[j]}),
      .o_nib(w_kcol[j])
    );
  end

  always_comb begin
    w_kr[0] = w_ir0;
    w_kr[1] = w_ir1;
    w_kr[2] = w_ir2;
    w_kr[3] = w_ir3;
    for (int j = 0; j < 4; j++) begin
      w_kr[0][j] = w_kcol[j][0];
      w_kr[1][j] = w_kcol[j][1];
      w_kr[2][j] = w_kcol[j][2];
      w_kr[3][j] = w_kcol[j][3];
    end
    w_key_inv = {w_ir4, w_kr[3], w_kr[2], w_kr[1], w_kr[0]};
  end

`ifdef RECT_DEC_KEYCACHE_EN
  logic [79:0] r_cache_key, r_cache_k25;
  logic        r_cache_vld;

  assign w_hit      = r_cache_vld && (key_in == r_cache_key);
  assign w_key_load = w_hit ? r_cache_k25 : key_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_key <= '0;
      r_cache_k25 <= '0;
      r_cache_vld <= 1'b0;
    end else begin
      if (r_state == IDLE && start && !w_hit) begin
        r_cache_key <= key_in;
        r_cache_vld <= 1'b0;
      end
      if (r_state == KEXP && r_rcnt == RC_LAST) begin
        r_cache_k25 <= w_key_fwd;
        r_cache_vld <= 1'b1;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_key_load = key_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_hit ? DEC : KEXP;
      KEXP:    if (r_rcnt == RC_LAST) w_next = DEC;
      DEC:     if (r_rcnt == 5'd0) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != IDLE);
    done   = r_done;
    pt_out = r_pt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= '0;
      r_key       <= '0;
      r_rcnt      <= '0;
      r_done      <= 1'b0;
      r_pt        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state_reg <= ct_in;
          r_key       <= w_key_load;
          r_rcnt      <= w_hit ? RC_LAST : 5'd0;
        end
        KEXP: begin
          r_key <= w_key_fwd;
          if (r_rcnt != RC_LAST) r_rcnt <= r_rcnt + 5'd1;
        end
        DEC: begin
          r_state_reg <= w_inv;
          r_key       <= w_key_inv;
          if (r_rcnt != 5'd0) r_rcnt <= r_rcnt - 5'd1;
        end
        FIN: begin
          r_pt   <= r_state_reg ^ r_key[63:0];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_decrypt.sv
// Scoreboard bench for rect_decrypt: plaintexts are encrypted by a reference encryptor,
// expected plaintext and latency are queued, and a monitor checks each done pulse.
module tb_rect_decrypt;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] ct_in;
  logic [79:0] key_in;
  logic        busy, done;
  logic [63:0] pt_out;

  rect_decrypt dut (
    .clk(clk), .rst(rst), .start(start), .ct_in(ct_in), .key_in(key_in),
    .busy(busy), .done(done), .pt_out(pt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pt;
    int          t0;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

`ifdef RECT_DEC_KEYCACHE_EN
  logic        m_vld = 1'b0;
  logic [79:0] m_key = '0;
`endif

  localparam logic [63:0] TB_SBOX = 64'h24F8_D30B_97E1_AC56;

  always @(posedge clk) cyc++;

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = TB_SBOX;
    return t[4*x +: 4];
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [79:0] kstep(input logic [79:0] k, input logic [4:0] rc);
    logic [15:0] r0, r1, r2, r3, r4, n0;
    logic [3:0]  nib;
    r0 = k[15:0]; r1 = k[31:16]; r2 = k[47:32]; r3 = k[63:48]; r4 = k[79:64];
    for (int j = 0; j < 4; j++) begin
      nib = sb({r3[j], r2[j], r1[j], r0[j]});
      r0[j] = nib[0]; r1[j] = nib[1]; r2[j] = nib[2]; r3[j] = nib[3];
    end
    n0 = rl(r0, 8) ^ r1;
    n0[4:0] = n0[4:0] ^ rc;
    return {r0, rl(r3, 12) ^ r4, r3, r2, n0};
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, t;
    logic [79:0] k;
    logic [4:0]  rc;
    logic [3:0]  nib;
    s = pt; k = key; rc = 5'h01;
    for (int r = 0; r < 25; r++) begin
      s = s ^ k[63:0];
      t = s;
      for (int j = 0; j < 16; j++) begin
        nib = sb({s[48+j], s[32+j], s[16+j], s[j]});
        t[j] = nib[0]; t[16+j] = nib[1]; t[32+j] = nib[2]; t[48+j] = nib[3];
      end
      s  = {rl(t[63:48], 13), rl(t[47:32], 12), rl(t[31:16], 1), t[15:0]};
      k  = kstep(k, rc);
      rc = {rc[3:0], rc[4] ^ rc[2]};
    end
    return s ^ k[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      chk("done_without_busy", {63'd0, busy}, 64'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done pt_out=%h required=no done", pt_out);
      end else begin
        e = q.pop_front();
        chk("pt_out", pt_out, e.pt);
        chk("latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_done pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic run_op(input logic [63:0] pt, input logic [79:0] key, input bit glitch);
    exp_t e;
    int   t0, lat;
    int   offs [3];
    offs = '{5, 20, 40};
    lat = 51;
`ifdef RECT_DEC_KEYCACHE_EN
    if (m_vld && key == m_key) lat = 26;
    else begin
      m_key = key;
      m_vld = 1'b1;
    end
`endif
    @(negedge clk);
    ct_in  = enc(pt, key);
    key_in = key;
    start  = 1'b1;
    t0     = cyc;
    e.pt = pt; e.t0 = t0; e.lat = lat;
    q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    ct_in  = {$urandom, $urandom};
    key_in = {16'($urandom), $urandom, $urandom};
    chk("busy_running", {63'd0, busy}, 64'd1);
    if (glitch) begin
      for (int g = 0; g < 3; g++) begin
        while (cyc < t0 + 1 + offs[g]) @(negedge clk);
        start  = 1'b1;
        ct_in  = {$urandom, $urandom};
        key_in = {16'($urandom), $urandom, $urandom};
        @(negedge clk);
        start  = 1'b0;
      end
    end
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; ct_in = '0; key_in = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_pt_out", pt_out, 64'd0);
    start = 1'b0;
    rst   = 1'b0;

    run_op(64'h0, 80'h0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0);

    run_op(64'h1111_2222_3333_4444, 80'h0123_4567_89AB_CDEF_0246, 1'b0);
    run_op(64'hA5A5_5A5A_0F0F_F0F0, 80'h0123_4567_89AB_CDEF_0246, 1'b0);
    run_op(64'h8000_0000_0000_0001, 80'hFEDC_BA98_7654_3210_1357, 1'b0);

    run_op(64'hDEAD_BEEF_CAFE_F00D, 80'h1357_9BDF_0246_8ACE_1122, 1'b1);
    repeat (60) @(negedge clk);

    @(negedge clk);
    ct_in  = enc(64'h0123_4567_89AB_CDEF, 80'h5555_AAAA_3333_CCCC_9999);
    key_in = 80'h5555_AAAA_3333_CCCC_9999;
    start  = 1'b1;
    t0     = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 36) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_pt_out", pt_out, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
`ifdef RECT_DEC_KEYCACHE_EN
    m_vld = 1'b0;
`endif
    repeat (60) @(negedge clk);
    run_op(64'h0F1E_2D3C_4B5A_6978, 80'h5555_AAAA_3333_CCCC_9999, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op({$urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 1'b0);
    end

    repeat (60) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
